// File: rtl/debounce_pkg.sv
// Shared constants for the push-button conditioning path: FSM state encoding
// and the qualification window sizes for hardware and simulation.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    // 10 ms at 100 MHz
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int SIM_STABLE_CYCLES     = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; also reused for the
// switch input at the top level.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Synchronizes and debounces a mechanical button, producing a clean level plus
// single-cycle press and release pulses.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic db_pulse,
    output logic db_release
);

    logic             w_btn_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_done;
    logic             w_waiting;
    logic             r_pulse;
    logic             r_release;
    logic             w_level;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (w_btn_s)
    );

    assign w_cnt_done = (r_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign w_waiting  = (r_state == WAIT_HIGH) || (r_state == WAIT_LOW);

    // Counter runs only while staying in a WAIT state; any exit clears it so
    // the next qualification always starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOW;
            r_cnt     <= '0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_waiting && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
            r_pulse   <= (r_state == WAIT_HIGH) && (w_next == HIGH);
            r_release <= (r_state == WAIT_LOW) && (w_next == LOW);
        end
    end

    // An opposite sample is checked before the count, so a flip on the final
    // qualifying cycle returns to the previous stable state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LOW:       if (w_btn_s) w_next = WAIT_HIGH;
            WAIT_HIGH: begin
                if (!w_btn_s)        w_next = LOW;
                else if (w_cnt_done) w_next = HIGH;
            end
            HIGH:      if (!w_btn_s) w_next = WAIT_LOW;
            WAIT_LOW:  begin
                if (w_btn_s)         w_next = HIGH;
                else if (w_cnt_done) w_next = LOW;
            end
            default:   w_next = LOW;
        endcase
    end

    always_comb begin
        w_level = 1'b0;
        if ((r_state == HIGH) || (r_state == WAIT_LOW)) w_level = 1'b1;
    end

    assign db_level   = w_level;
    assign db_pulse   = r_pulse;
    assign db_release = r_release;

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce at simulation scale
// (STABLE_CYCLES=8): reset, press, release, bounce and mid-qualification reset.
module tb_button_debounce;
    import debounce_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic db_level;
    logic db_pulse;
    logic db_release;

    int checks   = 0;
    int failures = 0;
    int npulse   = 0;
    int nrel     = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .STABLE_CYCLES (SIM_STABLE_CYCLES),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .db_pulse   (db_pulse),
        .db_release (db_release)
    );

    // Drive inputs, let one edge sample them, then observe 1 ns later.
    task automatic cyc(input logic b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        #1;
        if (db_pulse)   npulse++;
        if (db_release) nrel++;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic lv, input logic p, input logic r);
        chk({tag, "_level"},   db_level,   lv);
        chk({tag, "_pulse"},   db_pulse,   p);
        chk({tag, "_release"}, db_release, r);
    endtask

    // n cycles at a fixed input level, all outputs expected to stay low
    task automatic run0(input string tag, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(b, 1'b0);
            chk_out(tag, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // From HIGH: release first sampled at i=1, level falls after edge i=11
    task automatic do_release(input string tag);
        npulse = 0;
        nrel   = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b0);
            chk_out(tag, i < 11, 1'b0, i == 11);
        end
        chk_int({tag, "_rel_count"},   nrel,   1);
        chk_int({tag, "_pulse_count"}, npulse, 0);
    endtask

    initial begin
        btn_in = 1'b0;
        reset  = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cyc(i[0], 1'b1);
            chk_out("reset", 1'b0, 1'b0, 1'b0);
        end
        run0("idle", 1'b0, 4);

        // Clean press: first sampling edge is i=1, pulse after edge k+10 (i=11)
        npulse = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b0);
            chk_out("press", i >= 11, i == 11, 1'b0);
        end
        chk_int("press_pulse_count", npulse, 1);

        do_release("release");

        npulse = 0;
        nrel   = 0;
        run0("bounce", 1'b1, 5);
        run0("bounce", 1'b0, 2);
        run0("bounce", 1'b1, 6);
        run0("bounce", 1'b0, 3);
        run0("bounce", 1'b0, 12);
        // Exactly 8 high cycles: sync'd input drops as cnt hits 7, flip wins
        run0("edge8", 1'b1, 8);
        run0("edge8", 1'b0, 12);
        chk_int("bounce_pulse_count", npulse, 0);

        run0("settle_burst", 1'b1, 3);
        run0("settle_burst", 1'b0, 2);
        run0("settle_burst", 1'b1, 5);
        run0("settle_burst", 1'b0, 1);
        run0("settle_burst", 1'b1, 7);
        run0("settle_burst", 1'b0, 2);
        npulse = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b0);
            chk_out("settle", i >= 11, i == 11, 1'b0);
        end
        chk_int("settle_pulse_count", npulse, 1);

        do_release("release2");

        // Reset at edge k+6 discards the qualification in progress
        npulse = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0);
            chk_out("midq", 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1);
        chk_out("midq_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            cyc(1'b1, 1'b0);
            chk_out("requal", i >= 11, i == 11, 1'b0);
        end
        chk_int("requal_pulse_count", npulse, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
# button_debounce

Front-end conditioning stage for the counter/display design: takes the raw mechanical push-button, synchronizes it to `clk`, rejects contact bounce, and produces both a debounced level and a single-cycle press pulse. The press pulse drives the top level's `db_button` count-step input, so one physical press advances the up/down counter by exactly one. A single instance sits directly upstream of the counter in `top_level`.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronized-stable cycles required to accept a new level (10 ms at 100 MHz). Legal range is 2 or greater.
- `CNT_W`, default 20: stability counter width. Must satisfy 2^CNT_W ≥ STABLE_CYCLES.

Ports:
- `clk`, in, 1: system clock. The block uses this single clock only.
- `reset`, in, 1: synchronous, active-high reset.
- `btn_in`, in, 1: raw asynchronous button input. It bounces.
- `db_level`, out, 1: debounced button level.
- `db_pulse`, out, 1: one-cycle high on each accepted rising transition of `db_level` (a press).
- `db_release`, out, 1: one-cycle high on each accepted falling transition of `db_level` (a release).

## Operation
- Synchronizer: 2-flop chain on `btn_in` produces `btn_s`. All other logic uses only `btn_s`.
- FSM has four states: `LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`.
  - `LOW`: `db_level`=0. If `btn_s`=1, go to `WAIT_HIGH` and clear `cnt` to 0.
  - `WAIT_HIGH`: `db_level`=0.
    - If `btn_s`=0, go to `LOW` (bounce rejected).
    - Else if `cnt`==STABLE_CYCLES-1, go to `HIGH`.
    - Else increment `cnt`.
  - `HIGH`: `db_level`=1. If `btn_s`=0, go to `WAIT_LOW` and clear `cnt` to 0.
  - `WAIT_LOW`: `db_level`=1.
    - If `btn_s`=1, go to `HIGH`.
    - Else if `cnt`==STABLE_CYCLES-1, go to `LOW`.
    - Else increment `cnt`.
- `db_pulse` is registered. It is 1 for exactly the cycle in which the state first reads `HIGH` after `WAIT_HIGH`.
- `db_release` is registered. It is 1 for exactly the cycle in which the state first reads `LOW` after `WAIT_LOW`.
- `cnt` only increments inside a WAIT state, so it cannot wrap. Any opposite sample restarts qualification from 0 on the next entry to the WAIT state.
- A button held indefinitely produces exactly one `db_pulse`. There is no auto-repeat.

## Timing
- Reset values: state=`LOW`, `cnt`=0, both synchronizer flops=0, `db_level`=0, `db_pulse`=0, `db_release`=0.
- Press latency: let edge k be the first clock edge that samples `btn_in`=1, with the input held high from then on. Then `db_level` and `db_pulse` go high after edge k+STABLE_CYCLES+2, and `db_pulse` drops after edge k+STABLE_CYCLES+3.
- Release latency is symmetric, measured from the first edge that samples `btn_in`=0. It is STABLE_CYCLES+2 edges to `db_level`=0 and `db_release`=1.
- `db_pulse` and `db_release` are never high in the same cycle. Each is never high for 2 consecutive cycles.
- Reset asserted mid-operation, in any state: on the next edge all outputs and the state return to their reset values. No pulse is emitted for any qualification in progress.
- `btn_in` high while `reset` is high: after reset deasserts, the press is qualified normally and one `db_pulse` is emitted.
- `btn_s` flips in the same cycle that `cnt` reaches STABLE_CYCLES-1: the flip wins. The FSM returns to the previous stable state and emits no pulse.

## Structure
- Shared package `debounce_pkg` holds:
  - The 2-bit state encoding constants: `LOW`=0, `WAIT_HIGH`=1, `HIGH`=2, `WAIT_LOW`=3.
  - `DEFAULT_STABLE_CYCLES`=1_000_000.
  - A simulation-scale constant `SIM_STABLE_CYCLES`=8.
- The synchronizer is a natural sub-module, `sync_2ff`, with ports `clk`, `reset`, `d`, `q`. It is reused for `sw_uhdl` at the top level.
- The FSM, counter and pulse registers live in `button_debounce`.

## Test plan
All scenarios use STABLE_CYCLES=8, a 10 ns clock, and edges counted from reset release.
- Reset: hold `reset`=1 for 5 cycles with `btn_in` toggling → `db_level`, `db_pulse` and `db_release` all stay 0 throughout.
- Clean press: `btn_in`=1 first sampled at edge k and held for 40 cycles → `db_level` rises after edge k+10 and `db_pulse`=1 only in cycle k+10. Exactly one pulse over the 40 cycles.
- Bounce reject: `btn_in` toggles high 5 cycles, low 2, high 6, low 3, then stays low → `db_level`, `db_pulse` and `db_release` stay 0 the whole time.
- Bounce then settle: 3 short bursts (each under 8 cycles), then high held for 20 cycles → exactly one `db_pulse`, occurring 10 edges after the start of the final steady high.
- Release: from `HIGH`, `btn_in`=0 first sampled at edge m and held → `db_level` falls after edge m+10, `db_release`=1 for one cycle, and no `db_pulse`.
- Reset mid-qualification: press held, with `reset`=1 asserted for 1 cycle at k+6 → outputs stay 0 through the reset. After reset deasserts, the held press re-qualifies and `db_pulse` fires exactly once, 10 edges after reset release.
